csr_file: RTL and testbench

- Machine-mode CSR register file for the tiny4stage core.
- Consumes CSR write and read requests from two sources:
  - the interrupt arbiter, which writes mepc/mstatus/mcause on trap entry and mstatus on mret;
  - the execute stage, for csrrw/csrrs/csrrc instructions.
- Supplies the arbiter's inputs: mtvec, mepc, mstatus and the global interrupt enable.
- Also holds a free-running 64-bit cycle counter.

---
 rtl/csr_file.sv | 92 +++++++++
 tb/tb_csr_file.sv | 130 +++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file with two write sources, two read ports and a 64-bit cycle counter.
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int          CYCLE_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_data_i,
  input  logic [31:0] ex_raddr_i,
  output logic [31:0] ex_rdata_o,
  input  logic        int_we_i,
  input  logic [31:0] int_waddr_i,
  input  logic [31:0] int_data_i,
  input  logic [31:0] int_raddr_i,
  output logic [31:0] int_rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] cycle_q, cycle_d;
  logic [11:0] w_addr;
  logic [31:0] w_data;
  logic        w_ok;
  function automatic logic is_rw(input logic [11:0] a);
    return a == A_MSTATUS || a == A_MIE || a == A_MTVEC || a == A_MSCRATCH || a == A_MEPC || a == A_MCAUSE;
  endfunction
  function automatic logic [31:0] rd(input logic [11:0] a, input logic [31:0] ms, input logic [31:0] mi,
                                     input logic [31:0] mt, input logic [31:0] sc, input logic [31:0] ep,
                                     input logic [31:0] mc, input logic [63:0] cy);
    return a == A_MSTATUS  ? ms :
           a == A_MIE      ? mi :
           a == A_MTVEC    ? mt :
           a == A_MSCRATCH ? sc :
           a == A_MEPC     ? ep :
           a == A_MCAUSE   ? mc :
           a == A_CYCLE    ? cy[31:0] :
           a == A_CYCLEH   ? cy[63:32] : 32'h0;
  endfunction
  // The arbiter wins a same-cycle conflict; the ex write vanishes completely, including from the bypass.
  always_comb begin
    w_addr     = int_we_i ? int_waddr_i[11:0] : ex_waddr_i[11:0];
    w_data     = int_we_i ? int_data_i : ex_data_i;
    w_ok       = (int_we_i || ex_we_i) && is_rw(w_addr);
    mstatus_d  = (w_ok && w_addr == A_MSTATUS)  ? w_data : mstatus_q;
    mie_d      = (w_ok && w_addr == A_MIE)      ? w_data : mie_q;
    mtvec_d    = (w_ok && w_addr == A_MTVEC)    ? w_data : mtvec_q;
    mscratch_d = (w_ok && w_addr == A_MSCRATCH) ? w_data : mscratch_q;
    mepc_d     = (w_ok && w_addr == A_MEPC)     ? w_data : mepc_q;
    mcause_d   = (w_ok && w_addr == A_MCAUSE)   ? w_data : mcause_q;
    cycle_d    = (CYCLE_EN != 0) ? cycle_q + 64'd1 : 64'd0;
    ex_rdata_o  = (w_ok && w_addr == ex_raddr_i[11:0]) ? w_data :
                  rd(ex_raddr_i[11:0], mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, cycle_q);
    int_rdata_o = (w_ok && w_addr == int_raddr_i[11:0]) ? w_data :
                  rd(int_raddr_i[11:0], mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, cycle_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= 32'h0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      cycle_q    <= 64'h0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      cycle_q    <= cycle_d;
    end
  end
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_q;
  assign global_int_en_o = mstatus_q[3];
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed checks of csr_file reset, writes, bypass, arbitration, decode and the cycle counter.
module tb_csr_file;
  localparam logic [31:0] RST_VEC = 32'h0000_1000;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we, int_we;
  logic [31:0] ex_waddr, ex_data, ex_raddr, ex_rdata;
  logic [31:0] int_waddr, int_data, int_raddr, int_rdata;
  logic [31:0] mtvec, mepc, mstatus;
  logic        gie;
  int          n_checks = 0;
  int          n_fail = 0;
  csr_file #(.MTVEC_RST(RST_VEC), .CYCLE_EN(1)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_data_i(ex_data),
    .ex_raddr_i(ex_raddr), .ex_rdata_o(ex_rdata),
    .int_we_i(int_we), .int_waddr_i(int_waddr), .int_data_i(int_data),
    .int_raddr_i(int_raddr), .int_rdata_o(int_rdata),
    .mtvec_o(mtvec), .mepc_o(mepc), .mstatus_o(mstatus), .global_int_en_o(gie)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    ex_we = 1'b0;
    int_we = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    ex_we = 1'b0; ex_waddr = 32'h0; ex_data = 32'h0; ex_raddr = 32'hC00;
    int_we = 1'b0; int_waddr = 32'h0; int_data = 32'h0; int_raddr = 32'h300;
    repeat (2) @(negedge clk);
    chk("rst_mtvec", mtvec, RST_VEC);
    chk("rst_mstatus", mstatus, 32'h0);
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_gie", {31'b0, gie}, 32'h0);
    chk("rst_cycle", ex_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("cycle_first", ex_rdata, 32'h1);
    @(negedge clk);
    chk("cycle_second", ex_rdata, 32'h2);
    ex_we = 1'b1; ex_waddr = 32'h305; ex_data = 32'h0000_0100; ex_raddr = 32'h305;
    #1;
    chk("mtvec_bypass", ex_rdata, 32'h100);
    chk("mtvec_o_no_bypass", mtvec, RST_VEC);
    @(negedge clk);
    idle();
    #1;
    chk("mtvec_o", mtvec, 32'h100);
    chk("mtvec_read", ex_rdata, 32'h100);
    int_we = 1'b1; int_waddr = 32'h341; int_data = 32'h80; int_raddr = 32'h341;
    ex_we = 1'b1; ex_waddr = 32'h340; ex_data = 32'h55; ex_raddr = 32'h340;
    #1;
    chk("conflict_int_bypass", int_rdata, 32'h80);
    chk("conflict_ex_no_fwd", ex_rdata, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("conflict_mepc", mepc, 32'h80);
    chk("conflict_mscratch", ex_rdata, 32'h0);
    ex_we = 1'b1; ex_waddr = 32'h300; ex_data = 32'h8;
    @(negedge clk);
    idle();
    #1;
    chk("mie_set_gie", {31'b0, gie}, 32'h1);
    chk("mie_set_mstatus", mstatus, 32'h8);
    int_we = 1'b1; int_waddr = 32'h341; int_data = 32'h200;
    @(negedge clk);
    int_waddr = 32'h300; int_data = 32'h0;
    #1;
    chk("trap_gie_held", {31'b0, gie}, 32'h1);
    @(negedge clk);
    int_waddr = 32'h342; int_data = 32'h8000_0004;
    #1;
    chk("trap_gie_drop", {31'b0, gie}, 32'h0);
    chk("trap_mepc", mepc, 32'h200);
    @(negedge clk);
    idle();
    int_raddr = 32'h342;
    #1;
    chk("trap_mcause", int_rdata, 32'h8000_0004);
    ex_we = 1'b1; ex_waddr = 32'h0001_2340; ex_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    ex_raddr = 32'h340;
    #1;
    chk("alias_mscratch", ex_rdata, 32'hDEAD_BEEF);
    ex_raddr = 32'h0005_0305;
    #1;
    chk("alias_read_mtvec", ex_rdata, 32'h100);
    ex_we = 1'b1; ex_waddr = 32'h7FF; ex_data = 32'h1234; ex_raddr = 32'h7FF;
    #1;
    chk("unimpl_no_bypass", ex_rdata, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("unimpl_read", ex_rdata, 32'h0);
    force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    ex_we = 1'b1; ex_waddr = 32'hC00; ex_data = 32'h1234; ex_raddr = 32'hC00; int_raddr = 32'hC80;
    #1;
    chk("carry_pre_lo", ex_rdata, 32'hFFFF_FFFF);
    chk("carry_pre_hi", int_rdata, 32'h1);
    @(negedge clk);
    idle();
    #1;
    chk("carry_lo", ex_rdata, 32'h0);
    chk("carry_hi", int_rdata, 32'h2);
    @(negedge clk);
    chk("carry_next_lo", ex_rdata, 32'h1);
    rst = 1'b1;
    ex_we = 1'b1; ex_waddr = 32'h305; ex_data = 32'hABCD;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rst_dominates_mtvec", mtvec, RST_VEC);
    chk("rst_clears_cycle", ex_rdata, 32'h0);
    chk("rst_clears_cycleh", int_rdata, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
